nn_upsample: RTL and testbench
==============================

NN_UPSAMPLE -- requirements
Module: nn_upsample

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PIX_WIDTH, 8, pixel bit width
- SCALE, 2, integer replication factor per axis, SHALL be ≥2
- WIDTH, 14, input frame width in pixels
- HEIGHT, 14, input frame height in lines
REQ-002 Ports (name direction width meaning), one per line:
- clk  input  1  clock
- rst_n  input  1  reset; one clock, reset asynchronous and active-low
- clk_en  input  1  global clock enable; all state frozen when 0
- i_data  input  PIX_WIDTH  input pixel
- i_valid  input  1  input pixel valid
- i_sop  input  1  first pixel of input frame
- i_eop  input  1  last pixel of input frame
- ready  output  1  input-side ready; a pixel is accepted when i_valid && ready
- o_data  output  PIX_WIDTH  output pixel
- o_valid  output  1  output pixel valid
- o_sop  output  1  first pixel of output frame
- o_eop  output  1  last pixel of output frame
- ds_ready  input  1  downstream ready; an output beat transfers when o_valid && ds_ready && clk_en
- err_frame  output  1  one-cycle pulse on a framing error

Function
REQ-003 The block SHALL perform nearest-neighbour upsampling: a WIDTH x HEIGHT input frame becomes a (WIDTH*SCALE) x (HEIGHT*SCALE) output frame; out(r,c) = in(r/SCALE, c/SCALE).
REQ-004 One line buffer of WIDTH x PIX_WIDTH registers; counters: wr_col (0..WIDTH-1), src_row (0..HEIGHT-1), src_col (0..WIDTH-1), rep_col (0..SCALE-1), rep_row (0..SCALE-1).
REQ-005 FSM states: IDLE, FILL, EMIT.
REQ-006 IDLE: ready=clk_en; an accepted pixel with i_sop writes buf[0], wr_col<=1, src_row<=0, go FILL; accepted pixels without i_sop are discarded.
REQ-007 FILL: ready=clk_en; each accepted pixel writes buf[wr_col]; on the write at wr_col==WIDTH-1, wr_col<=0, clear src_col/rep_col/rep_row, go EMIT.
REQ-008 EMIT: ready=0; o_valid=1; o_data=buf[src_col]; on each transfer rep_col increments, wrapping to 0 and incrementing src_col; src_col wraps at WIDTH-1, incrementing rep_row.
REQ-009 On the transfer at src_col==WIDTH-1, rep_col==SCALE-1, rep_row==SCALE-1: if src_row==HEIGHT-1, go IDLE; else src_row+1, go FILL.
REQ-010 While o_valid && !ds_ready, o_data, o_sop and o_eop SHALL stay stable; no counter advances.
REQ-011 o_sop=EMIT && src_row==0 && rep_row==0 && src_col==0 && rep_col==0.
REQ-012 o_eop=EMIT && src_row==HEIGHT-1 && rep_row==SCALE-1 && src_col==WIDTH-1 && rep_col==SCALE-1.
REQ-013 Latency: first output beat SHALL be presented the cycle after the last pixel of an input line is accepted (o_valid high in that cycle).
REQ-014 Throughput: per input line, WIDTH input cycles plus WIDTH*SCALE*SCALE output transfers; no overlap of FILL and EMIT.
REQ-015 i_sop accepted in FILL SHALL abort the current frame: pixel written to buf[0], wr_col<=1, src_row<=0, err_frame pulses.
REQ-016 Accepted i_eop while not at the last pixel of the frame (src_row==HEIGHT-1, wr_col==WIDTH-1) SHALL pulse err_frame and return to IDLE without emitting; missing i_eop at the last pixel SHALL pulse err_frame but proceed normally.
REQ-017 clk_en=0 SHALL freeze all state; ready=0 and no transfer counts on either side.
REQ-018 err_frame SHALL be registered and high for exactly one enabled cycle per error.

Reset
REQ-019 rst_n low SHALL asynchronously force IDLE, all counters 0, err_frame=0; o_valid, o_sop, o_eop=0; line buffer contents need not reset.
REQ-020 Reset mid-frame SHALL drop the partial frame; the next output is only after a fresh i_sop.

Verification (WIDTH=4, HEIGHT=2, SCALE=2, PIX_WIDTH=8)
REQ-021 Frame 1,2,3,4 / 5,6,7,8 with ds_ready=1 -> output 1,1,2,2,3,3,4,4 twice then 5,5,...,8,8 twice; o_sop on first 1, o_eop on last 8, 32 beats.
REQ-022 Same frame, ds_ready toggling 1,0 -> identical sequence; o_data/o_sop/o_eop stable during stalls; ready=0 throughout EMIT.
REQ-023 i_sop reasserted at input pixel 3 of line 0 -> err_frame pulse once; output reflects the new frame only.
REQ-024 i_eop at pixel 2 of line 1 -> err_frame pulse, IDLE, no line-1 output, ready=1.
REQ-025 rst_n low during EMIT of line 0 -> o_valid=0 immediately; next frame output correct from its o_sop.
REQ-026 clk_en=0 for 5 cycles mid-EMIT with ds_ready=1 -> no beats lost or duplicated.

Source files
------------

// File: rtl/nn_upsample.sv
// Nearest-neighbour upsampler: buffers one input line, then replays it
// SCALE times horizontally and vertically before accepting the next line.
module nn_upsample #(
    parameter int PIX_WIDTH = 8,
    parameter int SCALE     = 2,
    parameter int WIDTH     = 14,
    parameter int HEIGHT    = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic [PIX_WIDTH-1:0] i_data,
    input  logic                 i_valid,
    input  logic                 i_sop,
    input  logic                 i_eop,
    output logic                 ready,
    output logic [PIX_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_sop,
    output logic                 o_eop,
    input  logic                 ds_ready,
    output logic                 err_frame
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int SW = $clog2(SCALE);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [SW-1:0] REP_LAST = SW'(SCALE - 1);

    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

    state_t state_q, state_d;

    logic [CW-1:0] wr_col_q, wr_col_d;
    logic [CW-1:0] src_col_q, src_col_d;
    logic [RW-1:0] src_row_q, src_row_d;
    logic [SW-1:0] rep_col_q, rep_col_d;
    logic [SW-1:0] rep_row_q, rep_row_d;
    logic          err_q, err_d;

    logic [PIX_WIDTH-1:0] line_q [WIDTH];

    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic          accept;
    logic          xfer;
    logic          frame_last;

    assign ready   = clk_en && (state_q != EMIT);
    assign accept  = i_valid && ready;
    assign o_valid = (state_q == EMIT);
    assign xfer    = o_valid && ds_ready && clk_en;
    assign o_data  = line_q[src_col_q];

    assign o_sop = (state_q == EMIT) && (src_row_q == '0) &&
                   (rep_row_q == '0) && (src_col_q == '0) &&
                   (rep_col_q == '0);
    assign o_eop = (state_q == EMIT) && (src_row_q == ROW_LAST) &&
                   (rep_row_q == REP_LAST) && (src_col_q == COL_LAST) &&
                   (rep_col_q == REP_LAST);

    assign err_frame = err_q;

    always_comb begin
        state_d    = state_q;
        wr_col_d   = wr_col_q;
        src_col_d  = src_col_q;
        src_row_d  = src_row_q;
        rep_col_d  = rep_col_q;
        rep_row_d  = rep_row_q;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = wr_col_q;
        frame_last = (src_row_q == ROW_LAST) && (wr_col_q == COL_LAST);

        unique case (state_q)
            IDLE: begin
                if (accept && i_sop) begin
                    wr_en     = 1'b1;
                    wr_idx    = '0;
                    wr_col_d  = CW'(1);
                    src_row_d = '0;
                    // A one-pixel "frame" tagged eop is only legal for 1x1
                    if (i_eop && (WIDTH * HEIGHT > 1)) begin
                        err_d    = 1'b1;
                        wr_col_d = '0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (i_sop) begin
                        wr_idx    = '0;
                        wr_col_d  = CW'(1);
                        src_row_d = '0;
                        err_d     = 1'b1;
                    end else if (i_eop && !frame_last) begin
                        err_d    = 1'b1;
                        wr_col_d = '0;
                        state_d  = IDLE;
                    end else if (wr_col_q == COL_LAST) begin
                        err_d     = frame_last && !i_eop;
                        wr_col_d  = '0;
                        src_col_d = '0;
                        rep_col_d = '0;
                        rep_row_d = '0;
                        state_d   = EMIT;
                    end else begin
                        wr_col_d = wr_col_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (rep_col_q != REP_LAST) begin
                        rep_col_d = rep_col_q + 1'b1;
                    end else begin
                        rep_col_d = '0;
                        if (src_col_q != COL_LAST) begin
                            src_col_d = src_col_q + 1'b1;
                        end else begin
                            src_col_d = '0;
                            if (rep_row_q != REP_LAST) begin
                                rep_row_d = rep_row_q + 1'b1;
                            end else begin
                                rep_row_d = '0;
                                if (src_row_q == ROW_LAST) begin
                                    state_d = IDLE;
                                end else begin
                                    src_row_d = src_row_q + 1'b1;
                                    state_d   = FILL;
                                end
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_col_q  <= '0;
            src_col_q <= '0;
            src_row_q <= '0;
            rep_col_q <= '0;
            rep_row_q <= '0;
            err_q     <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            wr_col_q  <= wr_col_d;
            src_col_q <= src_col_d;
            src_row_q <= src_row_d;
            rep_col_q <= rep_col_d;
            rep_row_q <= rep_row_d;
            err_q     <= err_d;
        end
    end

    // Line storage carries no reset; stale pixels are never emitted
    always_ff @(posedge clk) begin
        if (clk_en && wr_en) begin
            line_q[wr_idx] <= i_data;
        end
    end

endmodule

// File: tb/tb_nn_upsample.sv
// Directed bench for nn_upsample at WIDTH=4, HEIGHT=2, SCALE=2.
// Expected beats are generated from the input pixels by index arithmetic.
module tb_nn_upsample;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_sop;
    logic       i_eop;
    logic       ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_sop;
    logic       o_eop;
    logic       ds_ready;
    logic       err_frame;

    int nerr = 0;
    int nchk = 0;

    logic [7:0] px [8];
    logic [9:0] exp_q [$];
    logic       e;

    always #5 clk = ~clk;

    nn_upsample #(
        .PIX_WIDTH(8),
        .SCALE(2),
        .WIDTH(4),
        .HEIGHT(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_en(clk_en),
        .i_data(i_data),
        .i_valid(i_valid),
        .i_sop(i_sop),
        .i_eop(i_eop),
        .ready(ready),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_sop(o_sop),
        .o_eop(o_eop),
        .ds_ready(ds_ready),
        .err_frame(err_frame)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_px(input int base);
        for (int i = 0; i < 8; i++) px[i] = 8'(base + i);
    endtask

    // Beat word is {sop, eop, data}
    task automatic build_exp();
        logic s;
        logic f;
        exp_q.delete();
        for (int r = 0; r < 2; r++)
            for (int rr = 0; rr < 2; rr++)
                for (int c = 0; c < 4; c++)
                    for (int rc = 0; rc < 2; rc++) begin
                        s = (r == 0 && rr == 0 && c == 0 && rc == 0);
                        f = (r == 1 && rr == 1 && c == 3 && rc == 1);
                        exp_q.push_back({s, f, px[r*4+c]});
                    end
    endtask

    // Called at a falling edge; the next rising edge accepts the pixel
    task automatic send_pix(input logic [7:0] d, input logic s,
                            input logic f, output logic err);
        i_data  = d;
        i_valid = 1'b1;
        i_sop   = s;
        i_eop   = f;
        chk("ready_in", ready, 1);
        @(negedge clk);
        i_valid = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
        err     = err_frame;
    endtask

    task automatic send_line(input int row);
        logic er;
        for (int c = 0; c < 4; c++) begin
            send_pix(px[row*4+c], row == 0 && c == 0, row == 1 && c == 3, er);
            chk("err_quiet", er, 0);
        end
    endtask

    task automatic drain(input int n, input bit toggle, input int pause_at);
        int         got = 0;
        int         cyc = 0;
        bit         ph = 1'b1;
        bit         stalled = 1'b0;
        bit         paused = 1'b0;
        logic [9:0] held = '0;
        while (got < n && cyc < 400) begin
            if (stalled) chk("stall_hold", {o_sop, o_eop, o_data}, held);
            if (got == pause_at && !paused) begin
                paused   = 1'b1;
                held     = {o_sop, o_eop, o_data};
                ds_ready = 1'b1;
                clk_en   = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    cyc++;
                    chk("pause_hold", {o_sop, o_eop, o_data}, held);
                    chk("pause_ready", ready, 0);
                end
                clk_en = 1'b1;
            end
            ds_ready = toggle ? ph : 1'b1;
            ph = !ph;
            chk("emit_valid", o_valid, 1);
            chk("emit_ready", ready, 0);
            if (ds_ready) begin
                chk("beat", {o_sop, o_eop, o_data}, exp_q.pop_front());
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = {o_sop, o_eop, o_data};
            end
            @(negedge clk);
            cyc++;
        end
        ds_ready = 1'b1;
        chk("drain_count", got, n);
    endtask

    task automatic full_frame(input int base, input bit toggle);
        set_px(base);
        build_exp();
        send_line(0);
        drain(16, toggle, -1);
        chk("fill_no_valid", o_valid, 0);
        send_line(1);
        drain(16, toggle, -1);
        chk("idle_no_valid", o_valid, 0);
        chk("idle_ready", ready, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        clk_en   = 1'b1;
        i_data   = '0;
        i_valid  = 1'b0;
        i_sop    = 1'b0;
        i_eop    = 1'b0;
        ds_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_sop", o_sop, 0);
        chk("rst_o_eop", o_eop, 0);
        chk("rst_err", err_frame, 0);
        chk("rst_ready", ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        full_frame(1, 1'b0);
        full_frame(1, 1'b1);

        // sop re-asserted at pixel 3 of line 0 aborts and restarts
        set_px(20);
        build_exp();
        send_pix(8'd10, 1'b1, 1'b0, e);
        send_pix(8'd11, 1'b0, 1'b0, e);
        chk("abort_pre_err", e, 0);
        send_pix(8'd20, 1'b1, 1'b0, e);
        chk("abort_err", e, 1);
        send_pix(8'd21, 1'b0, 1'b0, e);
        chk("abort_err_once", e, 0);
        send_pix(8'd22, 1'b0, 1'b0, e);
        send_pix(8'd23, 1'b0, 1'b0, e);
        drain(16, 1'b0, -1);
        send_line(1);
        drain(16, 1'b0, -1);

        // early eop on line 1 drops back to IDLE
        set_px(1);
        build_exp();
        send_line(0);
        drain(16, 1'b0, -1);
        send_pix(8'd5, 1'b0, 1'b0, e);
        send_pix(8'd6, 1'b0, 1'b1, e);
        chk("early_eop_err", e, 1);
        chk("early_eop_valid", o_valid, 0);
        chk("early_eop_ready", ready, 1);
        send_pix(8'd7, 1'b0, 1'b0, e);
        chk("early_eop_err_once", e, 0);
        send_pix(8'd8, 1'b0, 1'b0, e);
        @(negedge clk);
        chk("early_eop_discard", o_valid, 0);

        // missing eop on the final pixel flags but still emits
        set_px(31);
        build_exp();
        send_line(0);
        drain(16, 1'b0, -1);
        send_pix(8'd35, 1'b0, 1'b0, e);
        send_pix(8'd36, 1'b0, 1'b0, e);
        send_pix(8'd37, 1'b0, 1'b0, e);
        send_pix(8'd38, 1'b0, 1'b0, e);
        chk("no_eop_err", e, 1);
        drain(16, 1'b0, -1);

        // reset during EMIT of line 0
        set_px(41);
        build_exp();
        send_line(0);
        drain(5, 1'b0, -1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_sop", o_sop, 0);
        chk("midrst_eop", o_eop, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_pix(8'd99, 1'b0, 1'b0, e);
        chk("postrst_discard", o_valid, 0);
        full_frame(51, 1'b0);

        // clock-enable pause mid-EMIT on both lines
        set_px(61);
        build_exp();
        send_line(0);
        drain(16, 1'b0, 6);
        send_line(1);
        drain(16, 1'b1, 3);
        chk("final_idle", o_valid, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
